// File: rtl/peripheral_apb4_pkg.sv
// Shared types and helpers for the APB4 requester arbiter.
// Holds the bus state encoding and default APB widths.
package peripheral_apb4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;
    localparam int MAX_PORTS  = 16;

    function automatic int unsigned onehot_to_index(
        input logic [MAX_PORTS-1:0] oh
    );
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | int'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past ptr.
// Grant is all-zero when en is low or nothing is requesting.
module peripheral_arbiter_rr
    import peripheral_apb4_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        idx
);

    logic [MAX_PORTS-1:0] gnt_w;
    logic [IW-1:0]        cand;
    logic                 found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = IW'((int'(ptr) + i) % NUM_PORTS);
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_w                = '0;
        gnt_w[NUM_PORTS-1:0] = gnt;
    end

    assign idx = IW'(onehot_to_index(gnt_w));

endmodule

// File: rtl/peripheral_arbiter_master_apb4.sv
// APB4 master shared by NUM_PORTS requesters through a round-robin arbiter.
// Every output is registered; completion is reported by a one-cycle done_o.
module peripheral_arbiter_master_apb4
    import peripheral_apb4_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PADDR_SIZE = APB_ADDR_W,
    parameter int PDATA_SIZE = APB_DATA_W
) (
    input  logic                              PRESETn,
    input  logic                              PCLK,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS*PADDR_SIZE-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]              write_i,
    input  logic [NUM_PORTS*PDATA_SIZE/8-1:0] strb_i,
    input  logic [NUM_PORTS*PDATA_SIZE-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]              done_o,
    output logic [PDATA_SIZE-1:0]             rdata_o,
    output logic                              err_o,
    output logic [NUM_PORTS-1:0]              grant_o,
    output logic                              PSEL,
    output logic                              PENABLE,
    output logic [PADDR_SIZE-1:0]             PADDR,
    output logic [PDATA_SIZE/8-1:0]           PSTRB,
    output logic [PDATA_SIZE-1:0]             PWDATA,
    output logic                              PWRITE,
    input  logic [PDATA_SIZE-1:0]             PRDATA,
    input  logic                              PREADY,
    input  logic                              PSLVERR
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = PDATA_SIZE / 8;

    apb_state_t state, state_d;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         win_idx;
    logic [NUM_PORTS-1:0]  elig;
    logic [NUM_PORTS-1:0]  arb_req;
    logic [NUM_PORTS-1:0]  win_gnt;
    logic                  xfer_end;
    logic                  arb_en;
    logic                  launch;
    logic [PADDR_SIZE-1:0] win_addr;
    logic [SW-1:0]         win_strb;
    logic [PDATA_SIZE-1:0] win_wdata;
    logic                  win_write;

    // A port in its done cycle is masked so it cannot be re-granted at once
    assign elig     = req_i & ~done_o;
    assign xfer_end = (state == ACCESS) && PREADY;
    assign arb_en   = (state == IDLE) || xfer_end;
    assign arb_req  = (state == ACCESS) ? (elig & ~grant_o) : elig;
    assign launch   = |win_gnt;

    assign win_addr  = addr_i[int'(win_idx)*PADDR_SIZE +: PADDR_SIZE];
    assign win_strb  = strb_i[int'(win_idx)*SW +: SW];
    assign win_wdata = wdata_i[int'(win_idx)*PDATA_SIZE +: PDATA_SIZE];
    assign win_write = write_i[win_idx];

    peripheral_arbiter_rr #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arb (
        .req(arb_req),
        .ptr(ptr),
        .en (arb_en),
        .gnt(win_gnt),
        .idx(win_idx)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (launch) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (xfer_end) state_d = launch ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr     <= IW'(NUM_PORTS - 1);
            done_o  <= '0;
            rdata_o <= '0;
            err_o   <= 1'b0;
            grant_o <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PSTRB   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
        end else begin
            done_o <= '0;
            if (state == SETUP) PENABLE <= 1'b1;
            if (xfer_end) begin
                PENABLE <= 1'b0;
                PSEL    <= 1'b0;
                grant_o <= '0;
                done_o  <= grant_o;
                err_o   <= PSLVERR;
                if (!PWRITE) rdata_o <= PRDATA;
            end
            // A new grant overrides the idle values set above
            if (launch) begin
                PSEL    <= 1'b1;
                grant_o <= win_gnt;
                ptr     <= win_idx;
                PADDR   <= win_addr;
                PWRITE  <= win_write;
                PWDATA  <= win_wdata;
                PSTRB   <= win_write ? win_strb : '0;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_arbiter_master_apb4.sv
// Self-checking bench: directed vector table, multi-cycle sequences,
// and random traffic checked against a rule-level arbitration model.
`timescale 1ns/1ps
module tb_peripheral_arbiter_master_apb4;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic             PRESETn;
    logic             PCLK;
    logic [NP-1:0]    req_i;
    logic [NP*AW-1:0] addr_i;
    logic [NP-1:0]    write_i;
    logic [NP*SW-1:0] strb_i;
    logic [NP*DW-1:0] wdata_i;
    logic [NP-1:0]    done_o;
    logic [DW-1:0]    rdata_o;
    logic             err_o;
    logic [NP-1:0]    grant_o;
    logic             PSEL;
    logic             PENABLE;
    logic [AW-1:0]    PADDR;
    logic [SW-1:0]    PSTRB;
    logic [DW-1:0]    PWDATA;
    logic             PWRITE;
    logic [DW-1:0]    PRDATA;
    logic             PREADY;
    logic             PSLVERR;

    int   checks    = 0;
    int   errors    = 0;
    int   wcnt      = 0;
    int   wait_cfg  = 0;
    int   cur_wait;
    logic err_cfg   = 1'b0;
    logic rand_mode = 1'b0;

    typedef struct {
        int           port;
        logic         wr;
        logic [15:0]  addr;
        logic [3:0]   strb;
        logic [31:0]  wdata;
        int           waits;
        logic         slverr;
        logic [31:0]  exp_rdata;
        logic         exp_err;
        logic [3:0]   exp_done;
    } vec_t;

    vec_t tbl[6];

    peripheral_arbiter_master_apb4 #(
        .NUM_PORTS (NP),
        .PADDR_SIZE(AW),
        .PDATA_SIZE(DW)
    ) dut (
        .PRESETn(PRESETn),
        .PCLK   (PCLK),
        .req_i  (req_i),
        .addr_i (addr_i),
        .write_i(write_i),
        .strb_i (strb_i),
        .wdata_i(wdata_i),
        .done_o (done_o),
        .rdata_o(rdata_o),
        .err_o  (err_o),
        .grant_o(grant_o),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PADDR  (PADDR),
        .PSTRB  (PSTRB),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        return {a, 16'h0000} ^ 32'h12145678;
    endfunction

    function automatic int oh_idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Behavioural APB slave: wait states counted from the first ACCESS cycle
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    always_comb cur_wait = rand_mode ? int'(PADDR[2:1]) : wait_cfg;
    assign PREADY  = PSEL && PENABLE && (wcnt >= cur_wait);
    assign PRDATA  = rd_val(PADDR);
    assign PSLVERR = rand_mode ? PADDR[0] : err_cfg;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_port(input int n, input logic wr,
                            input logic [AW-1:0] a, input logic [SW-1:0] s,
                            input logic [DW-1:0] wd);
        write_i[n]           = wr;
        addr_i[n*AW +: AW]   = a;
        strb_i[n*SW +: SW]   = s;
        wdata_i[n*DW +: DW]  = wd;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({PSEL, PENABLE, PWRITE, err_o, done_o,
                                grant_o, PADDR, PSTRB}), 64'd0);
        chk({nm, "_pwdata"}, 64'(PWDATA), 64'd0);
        chk({nm, "_rdata"}, 64'(rdata_o), 64'd0);
    endtask

    task automatic do_reset();
        req_i = '0;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        chk_zero("rst");
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   setup_n;
        int   acc_n;
        logic got;
        wait_cfg = v.waits;
        err_cfg  = v.slverr;
        set_port(v.port, v.wr, v.addr, v.strb, v.wdata);
        req_i[v.port] = 1'b1;
        setup_n = 0;
        acc_n   = 0;
        got     = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (PSEL && !PENABLE) begin
                setup_n++;
                chk("vec_paddr", 64'(PADDR), 64'(v.addr));
                chk("vec_pwrite", 64'(PWRITE), 64'(v.wr));
                chk("vec_pstrb", 64'(PSTRB), 64'(v.wr ? v.strb : 4'h0));
                if (v.wr) chk("vec_pwdata", 64'(PWDATA), 64'(v.wdata));
            end
            if (PSEL && PENABLE) acc_n++;
            if (done_o != '0) got = 1'b1;
        end
        req_i[v.port] = 1'b0;
        chk("vec_done_seen", 64'(got), 64'd1);
        chk("vec_done", 64'(done_o), 64'(v.exp_done));
        chk("vec_rdata", 64'(rdata_o), 64'(v.exp_rdata));
        chk("vec_err", 64'(err_o), 64'(v.exp_err));
        chk("vec_setup_cyc", 64'(setup_n), 64'd1);
        chk("vec_access_cyc", 64'(acc_n), 64'(v.waits + 1));
        tick();
        chk("vec_idle", 64'({PSEL, grant_o, done_o}), 64'd0);
    endtask

    task automatic seq_rr();
        int order[$];
        int exp3[3];
        int first_t;
        int last_t;
        logic got;
        exp3 = '{0, 1, 3};
        first_t = 0;
        last_t  = 0;
        do_reset();
        wait_cfg = 0;
        err_cfg  = 1'b0;
        set_port(0, 1'b0, 16'h0100, 4'h0, 32'h0);
        set_port(1, 1'b0, 16'h0104, 4'h0, 32'h0);
        set_port(3, 1'b0, 16'h010C, 4'h0, 32'h0);
        req_i = 4'b1011;
        for (int t = 0; t < 60 && order.size() < 6; t++) begin
            tick();
            if (PSEL && !PENABLE) begin
                if (order.size() == 0) first_t = t;
                last_t = t;
                order.push_back(oh_idx(grant_o));
            end
        end
        chk("rr_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size(); i++)
            chk("rr_order", 64'(order[i]), 64'(exp3[i % 3]));
        chk("rr_span", 64'(last_t - first_t), 64'd10);
        // Port 3 drops its request mid-transfer; it must still complete
        req_i = '0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (done_o != '0) got = 1'b1;
        end
        chk("drop_done", 64'(done_o), 64'(4'b1000));
        tick();
    endtask

    task automatic seq_single();
        int dt[3];
        int n;
        n = 0;
        dt = '{0, 0, 0};
        set_port(1, 1'b0, 16'h0044, 4'h0, 32'h0);
        req_i = 4'b0010;
        for (int t = 0; t < 40 && n < 3; t++) begin
            tick();
            if (done_o != '0) begin
                chk("single_done", 64'(done_o), 64'(4'b0010));
                chk("single_rdata", 64'(rdata_o), 64'h12505678);
                dt[n] = t;
                n++;
                if (n == 3) req_i = '0;
            end
        end
        chk("single_count", 64'(n), 64'd3);
        chk("single_gap1", 64'(dt[1] - dt[0]), 64'd4);
        chk("single_gap2", 64'(dt[2] - dt[1]), 64'd4);
        tick();
    endtask

    task automatic seq_reset();
        logic got;
        set_port(0, 1'b0, 16'h0020, 4'h0, 32'h0);
        wait_cfg = 6;
        req_i = 4'b0001;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (PSEL && PENABLE) got = 1'b1;
        end
        chk("mid_access_seen", 64'(got), 64'd1);
        tick();
        tick();
        #2;
        PRESETn = 1'b0;
        #1;
        chk_zero("mid_rst");
        tick();
        chk("mid_rst_no_done", 64'(done_o), 64'd0);
        @(negedge PCLK);
        PRESETn  = 1'b1;
        wait_cfg = 0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            if (done_o != '0) got = 1'b1;
        end
        chk("reissue_done", 64'(done_o), 64'(4'b0001));
        chk("reissue_rdata", 64'(rdata_o), 64'h12345678);
        req_i = '0;
        tick();
    endtask

    task automatic seq_random();
        logic [NP-1:0] active;
        logic [NP-1:0] p_req;
        logic [NP-1:0] p_done;
        logic [NP-1:0] p_grant;
        logic [NP-1:0] elig;
        logic [NP-1:0] expg;
        logic [AW-1:0] m_addr[NP];
        logic          m_wr[NP];
        logic [SW-1:0] m_strb[NP];
        logic [DW-1:0] m_wdata[NP];
        logic [DW-1:0] last_rd;
        int last_win;
        int w;
        int d;
        int issued;
        int completed;
        rand_mode = 1'b1;
        do_reset();
        active    = '0;
        p_req     = '0;
        p_done    = '0;
        p_grant   = '0;
        last_rd   = '0;
        last_win  = NP - 1;
        issued    = 0;
        completed = 0;
        for (int n = 0; n < NP; n++) begin
            m_addr[n]  = '0;
            m_wr[n]    = 1'b0;
            m_strb[n]  = '0;
            m_wdata[n] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (PSEL && !PENABLE) begin
                elig = p_req & ~p_done & ~p_grant;
                w = -1;
                for (int k = 1; k <= NP; k++)
                    if (w < 0 && elig[(last_win + k) % NP])
                        w = (last_win + k) % NP;
                expg = '0;
                if (w >= 0) expg[w] = 1'b1;
                chk("rnd_grant", 64'(grant_o), 64'(expg));
                if (w >= 0) begin
                    last_win = w;
                    chk("rnd_paddr", 64'(PADDR), 64'(m_addr[w]));
                    chk("rnd_pwrite", 64'(PWRITE), 64'(m_wr[w]));
                    chk("rnd_pstrb", 64'(PSTRB),
                        64'(m_wr[w] ? m_strb[w] : 4'h0));
                    if (m_wr[w])
                        chk("rnd_pwdata", 64'(PWDATA), 64'(m_wdata[w]));
                end
            end
            if (done_o != '0) begin
                chk("rnd_onehot", 64'($countones(done_o)), 64'd1);
                d = oh_idx(done_o);
                chk("rnd_pending", 64'(active[d]), 64'd1);
                if (!m_wr[d]) last_rd = rd_val(m_addr[d]);
                chk("rnd_rdata", 64'(rdata_o), 64'(last_rd));
                chk("rnd_err", 64'(err_o), 64'(m_addr[d][0]));
                active[d] = 1'b0;
                completed++;
            end
            p_done  = done_o;
            p_grant = grant_o;
            for (int n = 0; n < NP; n++) begin
                if (!active[n] && cyc < 2500 && $urandom_range(0, 3) == 0) begin
                    m_addr[n]  = AW'($urandom);
                    m_wr[n]    = 1'($urandom);
                    m_strb[n]  = SW'($urandom);
                    m_wdata[n] = $urandom;
                    active[n]  = 1'b1;
                    issued++;
                    set_port(n, m_wr[n], m_addr[n], m_strb[n], m_wdata[n]);
                end
            end
            req_i = active;
            p_req = req_i;
        end
        chk("rnd_drained", 64'(completed), 64'(issued));
        rand_mode = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b1;
        req_i   = '0;
        write_i = '0;
        addr_i  = '0;
        strb_i  = '0;
        wdata_i = '0;
        tbl[0] = '{0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 0, 1'b0,
                   32'h00000000, 1'b0, 4'b0001};
        tbl[1] = '{2, 1'b0, 16'h0020, 4'hF, 32'h00000000, 3, 1'b0,
                   32'h12345678, 1'b0, 4'b0100};
        tbl[2] = '{3, 1'b1, 16'h0030, 4'h3, 32'hCAFEF00D, 1, 1'b1,
                   32'h12345678, 1'b1, 4'b1000};
        tbl[3] = '{1, 1'b0, 16'h0044, 4'hA, 32'h00000000, 0, 1'b0,
                   32'h12505678, 1'b0, 4'b0010};
        tbl[4] = '{3, 1'b0, 16'h00F0, 4'h0, 32'h00000000, 2, 1'b1,
                   32'h12E45678, 1'b1, 4'b1000};
        tbl[5] = '{0, 1'b1, 16'h0002, 4'h5, 32'h01234567, 0, 1'b0,
                   32'h12E45678, 1'b0, 4'b0001};
        do_reset();
        foreach (tbl[i]) run_vec(tbl[i]);
        err_cfg = 1'b0;
        seq_rr();
        seq_single();
        seq_reset();
        seq_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_arbiter_master_apb4.md
Name: peripheral_arbiter_master_apb4

Overview:
- Synthesizable APB4 master that shares one APB4 bus among NUM_PORTS local requesters.
- Each requester has a simple request/done command interface.
- A round-robin arbiter picks one requester per transfer. A SETUP/ACCESS state machine drives the APB4 master signals and returns read data and the error status to the granted requester.
- Sits between DMA channel engines (or CPU-side agents) and the APB4 peripheral/register fabric.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16)
- PADDR_SIZE, 16, APB address width
- PDATA_SIZE, 32, APB data width (multiple of 8)

Ports:
- PRESETn  input  1  asynchronous, active-low reset
- PCLK  input  1  clock
- req_i  input  NUM_PORTS  per-requester transfer request, level
- addr_i  input  NUM_PORTS*PADDR_SIZE  flattened addresses; port n at slice n
- write_i  input  NUM_PORTS  1=write, 0=read
- strb_i  input  NUM_PORTS*PDATA_SIZE/8  flattened byte strobes
- wdata_i  input  NUM_PORTS*PDATA_SIZE  flattened write data
- done_o  output  NUM_PORTS  one-cycle completion pulse, one-hot or zero
- rdata_o  output  PDATA_SIZE  read data, valid while done_o!=0
- err_o  output  1  PSLVERR of the completed transfer, valid while done_o!=0
- grant_o  output  NUM_PORTS  one-hot current owner; zero when idle
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PADDR  output  PADDR_SIZE  APB address
- PSTRB  output  PDATA_SIZE/8  APB strobes
- PWDATA  output  PDATA_SIZE  APB write data
- PWRITE  output  1  APB direction
- PRDATA  input  PDATA_SIZE  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB slave error

Behaviour:
- Reset (async, PRESETn=0):
  - State IDLE; all outputs 0, including PADDR, PWDATA, PSTRB, rdata_o and grant_o.
  - RR pointer = NUM_PORTS-1, so port 0 has highest priority first.
- All outputs are registered; no combinational path from inputs to outputs.
- Requester contract:
  - Assert req_i[n] with stable addr/write/strb/wdata until done_o[n].
  - Drop req_i[n] on the edge ending the done cycle, or keep it high to request another transfer.
- Eligible set = req_i & ~done_o. A requester is never re-granted during its own done cycle.
- Arbitration is round-robin: search starts at pointer+1 mod NUM_PORTS. The pointer updates to the granted index on grant.
- IDLE:
  - If the eligible set is non-zero at an edge, latch the winner's payload onto PADDR/PWRITE/PWDATA/PSTRB.
  - Set PSEL=1, PENABLE=0, grant_o one-hot; go to SETUP.
- SETUP: exactly one cycle; next edge sets PENABLE=1; go to ACCESS.
- ACCESS:
  - Hold all APB outputs while PREADY=0. Wait states are unbounded; there is no timeout.
  - At the edge with PREADY=1: capture PRDATA into rdata_o (reads only; writes leave rdata_o unchanged) and PSLVERR into err_o. Pulse done_o[grant] for the following cycle. PENABLE=0.
  - If another port (not the current one) is eligible, go straight to SETUP with the new grant and payload, keeping PSEL=1 (back-to-back).
  - Otherwise set PSEL=0 and grant_o=0, go to IDLE. PADDR, PWDATA and PWRITE hold their last values.
- Reads drive PSTRB=0 (APB4 rule). Writes drive strb_i of the granted port.
- PSLVERR is ignored unless PREADY=1 in ACCESS. err_o=1 still completes the transfer normally.
- A requester dropping req_i mid-transfer has no effect: the transfer completes and done_o still pulses.
- Reset mid-transfer: immediate return to the reset state; no done_o is issued; requesters must reissue.
- Simultaneous requests resolve purely by the RR pointer. Throughput is one transfer per 2 cycles when no wait states and more than one port is requesting.

Decomposition:
- Package peripheral_apb4_pkg:
  - state enum: IDLE, SETUP, ACCESS
  - APB4 width localparams
  - helper function for one-hot-to-index
- Sub-module peripheral_arbiter_rr:
  - parameter NUM_PORTS
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant and index; purely combinational
- The pointer register lives in the top module.

Test Plan:
- Port0 write addr=0x0010 strb=0xF data=0xDEADBEEF, PREADY=1:
  - PSEL rises, PENABLE 1 cycle later, PWRITE=1.
  - done_o=0001 one cycle after the ACCESS edge; err_o=0.
- Port2 read addr=0x0020, 3 wait states, PRDATA=0x12345678:
  - ACCESS held 4 cycles, PSTRB=0.
  - done_o=0100 and rdata_o=0x12345678.
- Ports 0,1,3 request together, held high (continuous):
  - Grant order 0,1,3,0,1,3.
  - No IDLE between transfers (back-to-back SETUP); no port is granted twice in a row while others wait.
- Port1 alone, req kept high for 3 transfers:
  - An IDLE cycle occurs between each transfer (done mask).
  - 3 done_o[1] pulses.
- Port3 write with PSLVERR=1 at PREADY:
  - done_o=1000 with err_o=1.
  - The next transfer shows err_o=0.
- PRESETn low during ACCESS of a port0 read:
  - All outputs 0 immediately, no done_o.
  - After release, port0 is reissued and completes with correct rdata_o.
